// File: rtl/divider_16bit.sv
// Unsigned 16-bit restoring divider, one quotient bit per clock, MSB first; done 16 cycles after accepted start.
// No backpressure: start is taken only in IDLE or DONE and ignored while busy; divide-by-zero finishes in one cycle.
module divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [4:0]       cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // The partial remainder is always below the divisor, so bit WIDTH of the
  // 17-bit trial difference is a reliable sign bit.
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], q_bit};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd <= dividend;
            dvs <= divisor;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          dvd <= dvd << 1;
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) begin
            state     <= DONE;
            quotient  <= quo_next;
            remainder <= rem_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16bit.sv
// Directed checks of the divider plus a four-lane random regression against the division identity.
module tb_divider_16bit;

  localparam int NLANE   = 4;
  localparam int PERLANE = 2500;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  logic lanes_go = 1'b0;
  int lanes_fin = 0;

  always #5 clk = ~clk;

  divider_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request across one edge, then scramble operands to show they are not re-sampled.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    if (busy && done) check("busy_done_excl", 32'd1, 32'd0);
  endtask

  task automatic check_res(input string tag, input logic [15:0] q, input logic [15:0] r,
                           input logic z);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_q"}, 32'(quotient), 32'(q));
    check({tag, "_r"}, 32'(remainder), 32'(r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(z));
  endtask

  initial begin
    int lat, bcnt, ndone, t;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) step();
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    step();

    // 100/7: busy for 16 cycles, done at k+16
    start_op(16'd100, 16'd7);
    check("d100_busy0", 32'(busy), 32'd1);
    wait_done(lat, bcnt);
    check("d100_lat", lat, 16);
    check("d100_busycnt", bcnt, 16);
    check_res("d100", 16'd14, 16'd2, 1'b0);
    step();
    check("d100_pulse", 32'(done), 32'd0);
    check("d100_hold_q", 32'(quotient), 32'd14);
    check("d100_hold_r", 32'(remainder), 32'd2);

    start_op(16'hFFFF, 16'd1);
    wait_done(lat, bcnt);
    check_res("ffff_1", 16'hFFFF, 16'd0, 1'b0);
    step();
    start_op(16'd3, 16'd10);
    wait_done(lat, bcnt);
    check_res("3_10", 16'd0, 16'd3, 1'b0);
    step();
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(lat, bcnt);
    check_res("ffff_ffff", 16'd1, 16'd0, 1'b0);
    step();

    // divide by zero finishes in the cycle after acceptance
    start_op(16'd5, 16'd0);
    wait_done(lat, bcnt);
    check("dz_lat", lat, 0);
    check("dz_busycnt", bcnt, 0);
    check_res("dz", 16'hFFFF, 16'd5, 1'b1);
    step();
    check("dz_pulse", 32'(done), 32'd0);
    check("dz_dbz_hold", 32'(div_by_zero), 32'd1);

    // start during RUN is ignored
    start_op(16'd1000, 16'd3);
    check("ign_dbz_clr", 32'(div_by_zero), 32'd0);
    repeat (5) step();
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    step();
    start = 1'b0;
    wait_done(lat, bcnt);
    check("ign_lat", lat + 6, 16);
    check_res("ign", 16'd333, 16'd1, 1'b0);
    step();
    check("ign_idle_busy", 32'(busy), 32'd0);
    check("ign_idle_done", 32'(done), 32'd0);

    // back-to-back: second start lands in the DONE cycle
    start_op(16'd100, 16'd7);
    wait_done(lat, bcnt);
    check_res("b2b_first", 16'd14, 16'd2, 1'b0);
    start_op(16'd50, 16'd8);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_nodone", 32'(done), 32'd0);
    wait_done(lat, bcnt);
    check("b2b_lat", lat, 16);
    check_res("b2b_second", 16'd6, 16'd2, 1'b0);
    step();

    // reset at iteration 8 of 1000/3, with a start on the same edge
    start_op(16'd1000, 16'd3);
    repeat (7) step();
    rst = 1'b1; start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    step();
    rst = 1'b0; start = 1'b0;
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    ndone = 0;
    repeat (20) begin
      if (done || busy) ndone++;
      step();
    end
    check("mid_rst_quiet", ndone, 0);
    start_op(16'd100, 16'd7);
    wait_done(lat, bcnt);
    check("post_rst_lat", lat, 16);
    check_res("post_rst", 16'd14, 16'd2, 1'b0);
    step();

    lanes_go = 1'b1;
    t = 0;
    while (lanes_fin < NLANE && t < 60000) begin
      step();
      t++;
    end
    check("lanes_finished", lanes_fin, NLANE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Random regression spread over independent instances sharing clk and rst.
  for (genvar g = 0; g < NLANE; g++) begin : lane
    logic        l_start;
    logic [15:0] l_a, l_b, l_q, l_r;
    logic        l_busy, l_done, l_dbz;

    divider_16bit #(.WIDTH(16)) u_div (
      .clk(clk), .rst(rst), .start(l_start),
      .dividend(l_a), .divisor(l_b),
      .quotient(l_q), .remainder(l_r),
      .busy(l_busy), .done(l_done), .div_by_zero(l_dbz)
    );

    initial begin
      logic [15:0] a, b;
      int sel, lat;
      l_start = 1'b0; l_a = '0; l_b = '0;
      wait (lanes_go);
      @(posedge clk); #1;
      for (int n = 0; n < PERLANE; n++) begin
        sel = int'($urandom_range(0, 15));
        a   = 16'($urandom);
        if (sel == 0)     b = 16'd0;
        else if (sel < 5) b = 16'($urandom_range(1, 255));
        else              b = 16'($urandom);
        l_start = 1'b1; l_a = a; l_b = b;
        @(posedge clk); #1;
        l_start = 1'b0; l_a = 16'($urandom); l_b = 16'($urandom);
        lat = 0;
        while (!l_done && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        check("rnd_lat", lat, (b == 16'd0) ? 0 : 16);
        if (b == 16'd0) begin
          check("rnd_dz_q", 32'(l_q), 32'h0000FFFF);
          check("rnd_dz_r", 32'(l_r), 32'(a));
          check("rnd_dz_flag", 32'(l_dbz), 32'd1);
        end else begin
          check("rnd_ident", 32'(l_q) * 32'(l_b == l_b ? b : b) + 32'(l_r), 32'(a));
          check("rnd_rem_lt", 32'(l_r < b), 32'd1);
          check("rnd_dz_clr", 32'(l_dbz), 32'd0);
        end
      end
      lanes_fin++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/divider_16bit.md
DIVIDER_16BIT -- requirements
Module: divider_16bit

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width; only 16 is supported.
REQ-002 clk  input  1  rising-edge clock; the single clock domain of the block.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request a new division; sampled on the rising clk edge.
REQ-005 dividend  input  16  unsigned dividend; sampled only when start is accepted.
REQ-006 divisor  input  16  unsigned divisor; sampled only when start is accepted.
REQ-007 quotient  output  16  unsigned quotient, registered.
REQ-008 remainder  output  16  unsigned remainder, registered.
REQ-009 busy  output  1  high while an iteration is in progress.
REQ-010 done  output  1  one-cycle pulse; quotient and remainder are valid.
REQ-011 div_by_zero  output  1  high with done when the latched divisor was 0; holds until the next accepted start.

Function
REQ-012 The block SHALL implement unsigned restoring division, one quotient bit per clock, MSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands or state.
REQ-015 On acceptance at edge k, the block SHALL latch dividend and divisor, clear the partial remainder and the 5-bit iteration counter, and clear div_by_zero.
REQ-016 On acceptance with divisor != 0, the next state SHALL be RUN.
REQ-017 Each RUN edge SHALL do the following: shift the partial remainder left by one, inserting the next dividend bit; compute a 17-bit trial difference (remainder minus divisor); if the result is non-negative, keep the difference and set the quotient bit; otherwise restore and clear the bit.
REQ-018 The 16th RUN iteration SHALL complete at edge k+16 and move the FSM to DONE, so done is high during the cycle after edge k+16 (latency 16 cycles from acceptance).
REQ-019 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); busy and done SHALL never be high together.
REQ-020 From DONE, the next edge SHALL go to RUN if start is accepted, otherwise to IDLE; done SHALL be exactly one cycle wide.
REQ-021 On acceptance with divisor == 0, the FSM SHALL go directly to DONE at edge k and set quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
REQ-022 quotient and remainder SHALL hold their final values in IDLE until the next accepted start.
REQ-023 Input changes on dividend or divisor after acceptance SHALL NOT affect the result in progress.
REQ-024 Final results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor for every divisor != 0.

Reset
REQ-025 While rst is high at a clk edge, the block SHALL force state=IDLE and set quotient, remainder, the counter, busy, done and div_by_zero all to 0.
REQ-026 rst SHALL take priority over start and over any RUN iteration; an in-progress division SHALL be abandoned, with no done pulse.
REQ-027 start sampled on the same edge as rst SHALL be ignored.

Verification
REQ-028 The bench SHALL check: start with 100/7 at edge k -> busy high for 16 cycles, then done at k+16 with quotient=14, remainder=2, div_by_zero=0.
REQ-029 The bench SHALL check: 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0; 3/10 -> quotient=0, remainder=3; 16'hFFFF/16'hFFFF -> quotient=1, remainder=0.
REQ-030 The bench SHALL check: 5/0 -> done in the cycle after edge k with quotient=16'hFFFF, remainder=5, div_by_zero=1, and busy never high.
REQ-031 The bench SHALL check: 1000/3 started, start with 9/2 pulsed during RUN -> result is quotient=333, remainder=1, and the second request is ignored.
REQ-032 The bench SHALL check: back-to-back operation, with start asserted during the DONE cycle of 100/7 carrying 50/8 -> the second done occurs 16 cycles later with quotient=6, remainder=2.
REQ-033 The bench SHALL check: rst asserted at iteration 8 of 1000/3 -> next cycle shows all outputs 0 and state IDLE, no done pulse, and a following 100/7 completes correctly.
REQ-034 The bench SHALL run random regression of at least 10,000 operand pairs, checked against the REQ-024 identity and the REQ-021 zero-divisor rule.
